uart_rx: RTL

- UART receiver; consumer of the 16x oversampling tick from the baud-rate generator.
- Samples the serial `rx` line at mid-bit and assembles LSB-first data words.
- Presents each word on `dout` with a one-cycle `rx_done_tick` strobe and a stop-bit error flag.
- Sits between the pin-level `rx` input and the receive buffer / interface logic.

---
 rtl/uart_rx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 16x-oversampled UART receiver, LSB-first, mid-bit sampling,
//            stop-bit error flag. Optional parity via UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PAR_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd3;
`endif
    localparam logic [4:0] c_S_MID   = 5'd7;
    localparam logic [4:0] c_S_BIT   = 5'd15;
    localparam logic [4:0] c_S_STOP  = 5'(SB_TICK - 1);
    localparam logic [2:0] c_N_LAST  = 3'(DBIT - 1);
    localparam int         c_ALIGN   = 8 - DBIT;

    logic [1:0] r_sync;
    logic       w_rx_s;
    logic [2:0] r_state;
    logic [4:0] r_s;
    logic [2:0] r_n;
    logic [7:0] r_b;
    logic       r_wait_high;
`ifdef UART_RX_PARITY_EN
    logic       r_par_bit;
`endif

    // Synchronizer presets high so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], rx};
    end

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_s          <= 5'd0;
            r_n          <= 3'd0;
            r_b          <= 8'd0;
            r_wait_high  <= 1'b0;
            dout         <= 8'd0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // After a low stop bit (break) the line must go high
                    // before another falling edge can start a frame.
                    if (r_wait_high) begin
                        if (w_rx_s) r_wait_high <= 1'b0;
                    end else if (!w_rx_s) begin
                        r_state <= c_START;
                        r_s     <= 5'd0;
                    end
                end
                c_START: begin
                    if (s_tick) begin
                        if (r_s == c_S_MID) begin
                            if (!w_rx_s) begin
                                r_state <= c_DATA;
                                r_s     <= 5'd0;
                                r_n     <= 3'd0;
                            end else begin
                                r_state <= c_IDLE;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
                c_DATA: begin
                    if (s_tick) begin
                        if (r_s == c_S_BIT) begin
                            r_s <= 5'd0;
                            r_b <= {w_rx_s, r_b[7:1]};
                            if (r_n == c_N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= c_PARITY;
`else
                                r_state <= c_STOP;
`endif
                            end else begin
                                r_n <= r_n + 3'd1;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_PARITY: begin
                    if (s_tick) begin
                        if (r_s == c_S_BIT) begin
                            r_s       <= 5'd0;
                            r_par_bit <= w_rx_s;
                            r_state   <= c_STOP;
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
`endif
                c_STOP: begin
                    if (s_tick) begin
                        if (r_s == c_S_STOP) begin
                            dout         <= r_b >> c_ALIGN;
                            frame_err    <= ~w_rx_s;
                            rx_done_tick <= 1'b1;
                            r_wait_high  <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err   <= (^(r_b >> c_ALIGN)) ^ r_par_bit ^ PAR_ODD;
`endif
                            r_state      <= c_IDLE;
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
